// File: rtl/linalg_pkg.sv
// Shared width helpers for the stream tag path.
// Tag packing order is {valid, addr, chan, frame}.
package linalg_pkg;

    function automatic int addr_w_f(input int vec_len);
        return (vec_len > 1) ? $clog2(vec_len) : 1;
    endfunction

    function automatic int chan_w_f(input int n_chan);
        return (n_chan > 1) ? $clog2(n_chan) : 1;
    endfunction

    function automatic int tag_w_f(input int addr_w, input int chan_w, input int frame_w);
        return 1 + addr_w + chan_w + frame_w;
    endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register for packed tags.
// Advances only when en is high.
module tag_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0][W-1:0] stage_q;
    logic [DEPTH-1:0][W-1:0] stage_d;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stage_d[gi] = en ? din : stage_q[gi];
        end else begin : g_tail
            assign stage_d[gi] = en ? stage_q[gi-1] : stage_q[gi];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/stream_tag_aligner.sv
// Tags each input sample with bin/channel/frame, delays the tags to match a
// fixed-latency core, and monitors the core's valid against the prediction.
module stream_tag_aligner
    import linalg_pkg::*;
#(
    parameter int VEC_LEN = 512,
    parameter int N_CHAN  = 1,
    parameter int LATENCY = 15,
    parameter int GATED   = 0,
    parameter int FRAME_W = 16,
    parameter int ERR_W   = 8,
    localparam int ADDR_W = addr_w_f(VEC_LEN),
    localparam int CHAN_W = chan_w_f(N_CHAN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_valid,
    input  logic               sync_in,
    input  logic               core_valid,
    output logic [ADDR_W-1:0]  addr,
    output logic [CHAN_W-1:0]  chan,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               first,
    output logic               last,
    output logic               dout_valid,
    output logic               mismatch,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam int TAG_W = tag_w_f(ADDR_W, CHAN_W, FRAME_W);

    typedef struct packed {
        logic               valid;
        logic [ADDR_W-1:0]  addr;
        logic [CHAN_W-1:0]  chan;
        logic [FRAME_W-1:0] frame;
    } tag_t;

    // Tag of the most recent sample; the next tag is derived from it.
    logic [ADDR_W-1:0]  prev_addr_q,  prev_addr_d;
    logic [CHAN_W-1:0]  prev_chan_q,  prev_chan_d;
    logic [FRAME_W-1:0] prev_frame_q, prev_frame_d;
    logic               seen_q,       seen_d;
    logic               sync_pend_q,  sync_pend_d;
    logic               shifted_q,    shifted_d;
    logic               mismatch_q,   mismatch_d;
    logic [ERR_W-1:0]   err_cnt_q,    err_cnt_d;

    logic               sync_eff;
    logic               line_en;
    logic [ADDR_W-1:0]  inc_addr;
    logic [CHAN_W-1:0]  inc_chan;
    logic [FRAME_W-1:0] inc_frame;
    tag_t               cur_tag;
    tag_t               line_out;

    always_comb begin
        inc_addr  = prev_addr_q;
        inc_chan  = prev_chan_q;
        inc_frame = prev_frame_q;
        if (prev_chan_q == CHAN_W'(N_CHAN - 1)) begin
            inc_chan = '0;
            if (prev_addr_q == ADDR_W'(VEC_LEN - 1)) begin
                inc_addr  = '0;
                inc_frame = prev_frame_q + FRAME_W'(1);
            end else begin
                inc_addr = prev_addr_q + ADDR_W'(1);
            end
        end else begin
            inc_chan = prev_chan_q + CHAN_W'(1);
        end
    end

    // A sync before any sample has been tagged leaves the frame at 0.
    always_comb begin
        sync_eff      = din_valid & (sync_in | sync_pend_q);
        cur_tag.valid = din_valid;
        cur_tag.addr  = inc_addr;
        cur_tag.chan  = inc_chan;
        cur_tag.frame = inc_frame;
        if (!seen_q) begin
            cur_tag.addr  = '0;
            cur_tag.chan  = '0;
            cur_tag.frame = '0;
        end else if (sync_eff) begin
            cur_tag.addr  = '0;
            cur_tag.chan  = '0;
            cur_tag.frame = prev_frame_q + FRAME_W'(1);
        end
    end

    always_comb begin
        prev_addr_d  = prev_addr_q;
        prev_chan_d  = prev_chan_q;
        prev_frame_d = prev_frame_q;
        seen_d       = seen_q;
        sync_pend_d  = sync_pend_q;
        if (din_valid) begin
            prev_addr_d  = cur_tag.addr;
            prev_chan_d  = cur_tag.chan;
            prev_frame_d = cur_tag.frame;
            seen_d       = 1'b1;
            sync_pend_d  = 1'b0;
        end else if (sync_in) begin
            sync_pend_d = 1'b1;
        end
    end

    assign line_en   = (GATED != 0) ? din_valid : 1'b1;
    assign shifted_d = line_en;

    tag_delay_line #(
        .W     (TAG_W),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (line_en),
        .din  (cur_tag),
        .dout (line_out)
    );

    // In gated mode the output valid is a one-cycle pulse after each shift.
    assign dout_valid = line_out.valid & shifted_q;
    assign addr       = line_out.addr;
    assign chan       = line_out.chan;
    assign frame_cnt  = line_out.frame;
    assign first      = dout_valid && (line_out.addr == '0) && (line_out.chan == '0);
    assign last       = dout_valid && (line_out.addr == ADDR_W'(VEC_LEN - 1))
                                   && (line_out.chan == CHAN_W'(N_CHAN - 1));

    always_comb begin
        mismatch_d = mismatch_q;
        err_cnt_d  = err_cnt_q;
        if (dout_valid != core_valid) begin
            mismatch_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
    end

    assign mismatch = mismatch_q;
    assign err_cnt  = err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_addr_q  <= '0;
            prev_chan_q  <= '0;
            prev_frame_q <= '0;
            seen_q       <= 1'b0;
            sync_pend_q  <= 1'b0;
            shifted_q    <= 1'b0;
            mismatch_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            prev_addr_q  <= prev_addr_d;
            prev_chan_q  <= prev_chan_d;
            prev_frame_q <= prev_frame_d;
            seen_q       <= seen_d;
            sync_pend_q  <= sync_pend_d;
            shifted_q    <= shifted_d;
            mismatch_q   <= mismatch_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

endmodule
